// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM state encoding
// and the owner IDs of the two requesters.
`timescale 1ns/1ps
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbState_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and load/store.
// In: ifReq, lsReq, lsStreak. Out: one-hot grantIf/grantLs (or none).
`timescale 1ns/1ps
module mem_arb_prio #(
    parameter int MAX_LS_STREAK = 4,
    parameter int SW            = 3
) (
    input  logic          ifReq,
    input  logic          lsReq,
    input  logic [SW-1:0] lsStreak,
    output logic          grantIf,
    output logic          grantLs
);

    logic forced;

    always_comb begin
        grantIf = 1'b0;
        grantLs = 1'b0;
        forced  = (lsStreak == SW'(MAX_LS_STREAK));
        // Terms are mutually exclusive: LS wins a tie unless the
        // streak has saturated, in which case fetch is forced.
        unique case (1'b1)
            (lsReq && !(ifReq && forced)): grantLs = 1'b1;
            (ifReq && (!lsReq || forced)): grantIf = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (LS).
// Ports: iCLK/iRST; IF req/addr -> data/done; LS req/wr/wstrb/addr/wdata
// -> rdata/done; registered oMEM_* strobes, iMEM_RDATA return.
`timescale 1ns/1ps
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW            = 32,
    parameter int MEM_LAT       = 1,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iIF_REQ,
    input  logic [AW-1:0] iIF_ADDR,
    output logic [31:0]   oIF_DATA,
    output logic          oIF_DONE,
    input  logic          iLS_REQ,
    input  logic          iLS_WR,
    input  logic [3:0]    iLS_WSTRB,
    input  logic [AW-1:0] iLS_ADDR,
    input  logic [31:0]   iLS_WDATA,
    output logic [31:0]   oLS_RDATA,
    output logic          oLS_DONE,
    output logic          oMEM_CE,
    output logic          oMEM_RD,
    output logic          oMEM_WR,
    output logic [3:0]    oMEM_WSTRB,
    output logic [AW-1:0] oMEM_ADDR,
    output logic [31:0]   oMEM_WDATA,
    input  logic [31:0]   iMEM_RDATA
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = (MAX_LS_STREAK > 0) ? $clog2(MAX_LS_STREAK + 1) : 1;

    arbState_t     state;
    arbState_t     nextState;
    owner_t        owner;
    logic [CW-1:0] cnt;
    logic [SW-1:0] lsStreak;
    logic          grantIf;
    logic          grantLs;

    mem_arb_prio #(
        .MAX_LS_STREAK(MAX_LS_STREAK),
        .SW           (SW)
    ) uPrio (
        .ifReq   (iIF_REQ),
        .lsReq   (iLS_REQ),
        .lsStreak(lsStreak),
        .grantIf (grantIf),
        .grantLs (grantLs)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (grantIf || grantLs) nextState = ACCESS;
            ACCESS:  if (cnt == '0) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // The oMEM_* registers double as the latched request: they are
    // loaded on grant, held through ACCESS and cleared on exit.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            owner      <= OWN_IF;
            cnt        <= '0;
            lsStreak   <= '0;
            oMEM_CE    <= 1'b0;
            oMEM_RD    <= 1'b0;
            oMEM_WR    <= 1'b0;
            oMEM_WSTRB <= '0;
            oMEM_ADDR  <= '0;
            oMEM_WDATA <= '0;
            oIF_DATA   <= '0;
            oIF_DONE   <= 1'b0;
            oLS_RDATA  <= '0;
            oLS_DONE   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grantIf) begin
                        owner      <= OWN_IF;
                        cnt        <= CW'(MEM_LAT - 1);
                        lsStreak   <= '0;
                        oMEM_CE    <= 1'b1;
                        oMEM_RD    <= 1'b1;
                        oMEM_WR    <= 1'b0;
                        oMEM_WSTRB <= '0;
                        oMEM_ADDR  <= iIF_ADDR;
                        oMEM_WDATA <= '0;
                    end else if (grantLs) begin
                        owner      <= OWN_LS;
                        cnt        <= CW'(MEM_LAT - 1);
                        oMEM_CE    <= 1'b1;
                        oMEM_RD    <= ~iLS_WR;
                        oMEM_WR    <= iLS_WR;
                        oMEM_WSTRB <= iLS_WR ? iLS_WSTRB : 4'h0;
                        oMEM_ADDR  <= iLS_ADDR;
                        oMEM_WDATA <= iLS_WDATA;
                        // Streak only counts LS wins over a waiting fetch.
                        if (!iIF_REQ) begin
                            lsStreak <= '0;
                        end else if (lsStreak != SW'(MAX_LS_STREAK)) begin
                            lsStreak <= lsStreak + SW'(1);
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        oMEM_CE    <= 1'b0;
                        oMEM_RD    <= 1'b0;
                        oMEM_WR    <= 1'b0;
                        oMEM_WSTRB <= '0;
                        oMEM_ADDR  <= '0;
                        oMEM_WDATA <= '0;
                        if (owner == OWN_IF) begin
                            oIF_DATA <= iMEM_RDATA;
                            oIF_DONE <= 1'b1;
                        end else begin
                            if (!oMEM_WR) oLS_RDATA <= iMEM_RDATA;
                            oLS_DONE <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    oIF_DONE <= 1'b0;
                    oLS_DONE <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: instance A at MEM_LAT=1,
// instance B at MEM_LAT=3, each with a small memory model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    logic        ifReqA, lsReqA, lsWrA;
    logic [31:0] ifAddrA, lsAddrA, lsWdataA;
    logic [3:0]  lsWstrbA;
    logic [31:0] ifDataA, lsRdataA, memAddrA, memWdataA, memRdataA;
    logic        ifDoneA, lsDoneA, memCeA, memRdA, memWrA;
    logic [3:0]  memWstrbA;

    logic        ifReqB, lsReqB, lsWrB;
    logic [31:0] ifAddrB, lsAddrB, lsWdataB;
    logic [3:0]  lsWstrbB;
    logic [31:0] ifDataB, lsRdataB, memAddrB, memWdataB, memRdataB;
    logic        ifDoneB, lsDoneB, memCeB, memRdB, memWrB;
    logic [3:0]  memWstrbB;

    assign memRdataA = (memAddrA == 32'h10) ? 32'h00500093 : 32'hFFFFFFFF;
    assign memRdataB = 32'hC0DE0000 | {16'h0, memAddrB[15:0]};

    mem_bus_arbiter #(.AW(32), .MEM_LAT(1), .MAX_LS_STREAK(4)) dutA (
        .iCLK(iCLK), .iRST(iRST),
        .iIF_REQ(ifReqA), .iIF_ADDR(ifAddrA),
        .oIF_DATA(ifDataA), .oIF_DONE(ifDoneA),
        .iLS_REQ(lsReqA), .iLS_WR(lsWrA), .iLS_WSTRB(lsWstrbA),
        .iLS_ADDR(lsAddrA), .iLS_WDATA(lsWdataA),
        .oLS_RDATA(lsRdataA), .oLS_DONE(lsDoneA),
        .oMEM_CE(memCeA), .oMEM_RD(memRdA), .oMEM_WR(memWrA),
        .oMEM_WSTRB(memWstrbA), .oMEM_ADDR(memAddrA),
        .oMEM_WDATA(memWdataA), .iMEM_RDATA(memRdataA)
    );

    mem_bus_arbiter #(.AW(32), .MEM_LAT(3), .MAX_LS_STREAK(4)) dutB (
        .iCLK(iCLK), .iRST(iRST),
        .iIF_REQ(ifReqB), .iIF_ADDR(ifAddrB),
        .oIF_DATA(ifDataB), .oIF_DONE(ifDoneB),
        .iLS_REQ(lsReqB), .iLS_WR(lsWrB), .iLS_WSTRB(lsWstrbB),
        .iLS_ADDR(lsAddrB), .iLS_WDATA(lsWdataB),
        .oLS_RDATA(lsRdataB), .oLS_DONE(lsDoneB),
        .oMEM_CE(memCeB), .oMEM_RD(memRdB), .oMEM_WR(memWrB),
        .oMEM_WSTRB(memWstrbB), .oMEM_ADDR(memAddrB),
        .oMEM_WDATA(memWdataB), .iMEM_RDATA(memRdataB)
    );

    task automatic tick;
        @(posedge iCLK);
        #1;
    endtask

    task automatic test_reset;
        iRST = 1'b1;
        ifReqA = 0; lsReqA = 0; lsWrA = 0; lsWstrbA = 0;
        ifAddrA = 0; lsAddrA = 0; lsWdataA = 0;
        ifReqB = 0; lsReqB = 0; lsWrB = 0; lsWstrbB = 0;
        ifAddrB = 0; lsAddrB = 0; lsWdataB = 0;
        tick(); tick();
        checks++;
        if ({ifDataA, ifDoneA, lsRdataA, lsDoneA, memCeA, memRdA, memWrA,
             memWstrbA, memAddrA, memWdataA} !== '0) begin
            errors++;
            $display("FAIL reset_outs_A: got nonzero outputs ce=%b rd=%b wr=%b addr=%h, expected all 0",
                     memCeA, memRdA, memWrA, memAddrA);
        end
        checks++;
        if ({ifDataB, ifDoneB, lsRdataB, lsDoneB, memCeB, memRdB, memWrB,
             memWstrbB, memAddrB, memWdataB} !== '0) begin
            errors++;
            $display("FAIL reset_outs_B: got nonzero outputs ce=%b rd=%b wr=%b addr=%h, expected all 0",
                     memCeB, memRdB, memWrB, memAddrB);
        end
        iRST = 1'b0;
        tick();
        checks++;
        if ({memCeA, ifDoneA, lsDoneA, memCeB, ifDoneB, lsDoneB} !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 000000",
                     {memCeA, ifDoneA, lsDoneA, memCeB, ifDoneB, lsDoneB});
        end
    endtask

    task automatic test_if_lat1;
        ifAddrA = 32'h10;
        ifReqA  = 1'b1;
        tick();
        checks++;
        if ({memCeA, memRdA, memWrA, memWstrbA, ifDoneA} !== 8'b1100_0000) begin
            errors++;
            $display("FAIL lat1_access_strobes: got %b expected 11000000",
                     {memCeA, memRdA, memWrA, memWstrbA, ifDoneA});
        end
        checks++;
        if (memAddrA !== 32'h10) begin
            errors++;
            $display("FAIL lat1_addr: got %h expected 00000010", memAddrA);
        end
        tick();
        checks++;
        if ({ifDoneA, lsDoneA, memCeA, memRdA} !== 4'b1000) begin
            errors++;
            $display("FAIL lat1_done: got %b expected 1000",
                     {ifDoneA, lsDoneA, memCeA, memRdA});
        end
        checks++;
        if (ifDataA !== 32'h00500093) begin
            errors++;
            $display("FAIL lat1_data: got %h expected 00500093", ifDataA);
        end
        ifReqA = 1'b0;
        tick();
        checks++;
        if ({ifDoneA, memCeA} !== 2'b00) begin
            errors++;
            $display("FAIL lat1_idle: got %b expected 00", {ifDoneA, memCeA});
        end
    endtask

    task automatic test_load;
        lsAddrB = 32'h44;
        lsWrB   = 1'b0;
        lsWstrbB = 4'hF;
        lsReqB  = 1'b1;
        tick();
        checks++;
        if ({memCeB, memRdB, memWrB, memWstrbB} !== 7'b110_0000) begin
            errors++;
            $display("FAIL load_strobes: got %b expected 1100000",
                     {memCeB, memRdB, memWrB, memWstrbB});
        end
        tick(); tick(); tick();
        checks++;
        if ({lsDoneB, ifDoneB} !== 2'b10 || lsRdataB !== 32'hC0DE0044) begin
            errors++;
            $display("FAIL load_done: got done=%b data=%h expected done=10 data=c0de0044",
                     {lsDoneB, ifDoneB}, lsRdataB);
        end
        lsReqB = 1'b0;
        tick();
    endtask

    task automatic test_store;
        lsAddrB  = 32'h80;
        lsWdataB = 32'hDEADBEEF;
        lsWstrbB = 4'h3;
        lsWrB    = 1'b1;
        lsReqB   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({memCeB, memRdB, memWrB, memWstrbB} !== 7'b101_0011 ||
                memAddrB !== 32'h80 || memWdataB !== 32'hDEADBEEF ||
                lsDoneB !== 1'b0) begin
                errors++;
                $display("FAIL store_cycle%0d: got ctl=%b addr=%h wdata=%h done=%b expected ctl=1010011 addr=00000080 wdata=deadbeef done=0",
                         i, {memCeB, memRdB, memWrB, memWstrbB}, memAddrB,
                         memWdataB, lsDoneB);
            end
            lsAddrB  = 32'h123;
            lsWdataB = 32'h0;
            lsWstrbB = 4'hF;
            lsWrB    = 1'b0;
        end
        tick();
        checks++;
        if ({lsDoneB, memCeB, memWrB} !== 3'b100 || lsRdataB !== 32'hC0DE0044) begin
            errors++;
            $display("FAIL store_done: got done/ce/wr=%b rdata=%h expected 100 rdata=c0de0044",
                     {lsDoneB, memCeB, memWrB}, lsRdataB);
        end
        lsReqB = 1'b0;
        tick();
    endtask

    task automatic test_streak;
        int n = 0;
        int cyc = 0;
        bit both = 1'b0;
        logic [9:0] got = '0;
        ifAddrB = 32'h200;
        lsAddrB = 32'h400;
        lsWrB   = 1'b0;
        ifReqB  = 1'b1;
        lsReqB  = 1'b1;
        while (n < 10 && cyc < 200) begin
            tick();
            cyc++;
            if (ifDoneB && lsDoneB) both = 1'b1;
            if (lsDoneB) begin
                got = {got[8:0], 1'b1};
                n++;
            end else if (ifDoneB) begin
                got = {got[8:0], 1'b0};
                n++;
                checks++;
                if (ifDataB !== 32'hC0DE0200) begin
                    errors++;
                    $display("FAIL streak_if_data: got %h expected c0de0200", ifDataB);
                end
            end
        end
        ifReqB = 1'b0;
        lsReqB = 1'b0;
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL streak_timeout: got %0d dones expected 10", n);
        end
        checks++;
        if (got !== 10'b1111011110) begin
            errors++;
            $display("FAIL streak_order: got %b expected 1111011110 (1=LS)", got);
        end
        checks++;
        if (both) begin
            errors++;
            $display("FAIL streak_dual_done: got both DONE high expected never");
        end
        tick();
    endtask

    task automatic test_simultaneous;
        int lsAt = 0;
        int ifAt = 0;
        logic [31:0] lsD = '0;
        logic [31:0] ifD = '0;
        ifAddrB = 32'h304;
        lsAddrB = 32'h300;
        lsWrB   = 1'b0;
        ifReqB  = 1'b1;
        lsReqB  = 1'b1;
        for (int c = 1; c <= 30 && ifAt == 0; c++) begin
            tick();
            if (lsDoneB) begin
                lsAt = c; lsD = lsRdataB; lsReqB = 1'b0;
            end
            if (ifDoneB) begin
                ifAt = c; ifD = ifDataB; ifReqB = 1'b0;
            end
        end
        ifReqB = 1'b0;
        lsReqB = 1'b0;
        checks++;
        if (lsAt != 4 || lsD !== 32'hC0DE0300) begin
            errors++;
            $display("FAIL simul_ls: got cycle %0d data %h expected cycle 4 data c0de0300", lsAt, lsD);
        end
        checks++;
        if (ifAt != 9 || ifD !== 32'hC0DE0304) begin
            errors++;
            $display("FAIL simul_if: got cycle %0d data %h expected cycle 9 data c0de0304", ifAt, ifD);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        ifAddrB = 32'h40;
        ifReqB  = 1'b1;
        tick(); tick();
        checks++;
        if ({memCeB, memRdB} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_pre: got %b expected 11", {memCeB, memRdB});
        end
        iRST = 1'b1;
        #1;
        checks++;
        if ({ifDataB, ifDoneB, lsRdataB, lsDoneB, memCeB, memRdB, memWrB,
             memWstrbB, memAddrB, memWdataB} !== '0) begin
            errors++;
            $display("FAIL rstmid_outs: got ce=%b rd=%b addr=%h ifdata=%h expected all 0",
                     memCeB, memRdB, memAddrB, ifDataB);
        end
        tick();
        checks++;
        if ({ifDoneB, memCeB} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_hold: got %b expected 00", {ifDoneB, memCeB});
        end
        iRST = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c < 4) begin
                checks++;
                if ({memCeB, memRdB, memAddrB, ifDoneB} !== {2'b11, 32'h40, 1'b0}) begin
                    errors++;
                    $display("FAIL rstmid_restart_c%0d: got ce/rd=%b addr=%h done=%b expected 11 00000040 0",
                             c, {memCeB, memRdB}, memAddrB, ifDoneB);
                end
            end else begin
                checks++;
                if (ifDoneB !== 1'b1 || ifDataB !== 32'hC0DE0040) begin
                    errors++;
                    $display("FAIL rstmid_done: got done=%b data=%h expected 1 c0de0040",
                             ifDoneB, ifDataB);
                end
                ifReqB = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [9:0] doneV = '0;
        logic [9:0] ceV = '0;
        ifAddrB = 32'h60;
        ifReqB  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            doneV[c-1] = ifDoneB;
            ceV[c-1]   = memCeB;
            if (c == 9) ifReqB = 1'b0;
        end
        checks++;
        if (doneV !== 10'b0100001000) begin
            errors++;
            $display("FAIL b2b_done: got %b expected 0100001000", doneV);
        end
        checks++;
        if (ceV !== 10'b0011100111) begin
            errors++;
            $display("FAIL b2b_ce: got %b expected 0011100111", ceV);
        end
        checks++;
        if (ifDataB !== 32'hC0DE0060) begin
            errors++;
            $display("FAIL b2b_data: got %h expected c0de0060", ifDataB);
        end
    endtask

    initial begin
        test_reset();
        test_if_lat1();
        test_load();
        test_store();
        test_streak();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one single-port unified memory between the core's instruction-fetch port (IF, read-only) and its load/store port (LS, read/write with byte strobes). Sits between riscv core and the memory macro, replacing separate ROM/RAM paths. LS normally has priority, and a streak counter prevents fetch starvation. Each access occupies the memory for a fixed MEM_LAT cycles, then returns a one-cycle DONE pulse to the granted requester.

Parameters:
AW, 32, address width in bits (byte address, passed through unshifted)
MEM_LAT, 1, memory access latency in cycles (>=1); memory strobes are held this long
MAX_LS_STREAK, 4, maximum consecutive LS grants while IF is pending before IF is forced

Ports:
iCLK  in  1  clock
iRST  in  1  reset, asynchronous, active-high
iIF_REQ  in  1  fetch request, level, held until oIF_DONE
iIF_ADDR  in  AW  fetch byte address
oIF_DATA  out  32  fetched word, registered, valid with oIF_DONE
oIF_DONE  out  1  one-cycle completion pulse for IF
iLS_REQ  in  1  load/store request, level, held until oLS_DONE
iLS_WR  in  1  1 = store, 0 = load
iLS_WSTRB  in  4  byte enables for store
iLS_ADDR  in  AW  load/store byte address
iLS_WDATA  in  32  store data
oLS_RDATA  out  32  load data, registered, valid with oLS_DONE
oLS_DONE  out  1  one-cycle completion pulse for LS
oMEM_CE  out  1  memory chip enable
oMEM_RD  out  1  memory read strobe
oMEM_WR  out  1  memory write strobe
oMEM_WSTRB  out  4  memory byte enables (0 on reads)
oMEM_ADDR  out  AW  memory byte address
oMEM_WDATA  out  32  memory write data
iMEM_RDATA  in  32  memory read data, valid at the last ACCESS cycle

Behaviour:
- Reset (async): state IDLE; all outputs 0; latency counter 0; ls_streak 0; latched address, data and owner cleared. Reset mid-access aborts the access with no DONE pulse.
- FSM states:
  - IDLE: evaluate requests; on grant, latch owner, addr, wr, wstrb and wdata; go to ACCESS and load cnt = MEM_LAT-1.
  - ACCESS: drive oMEM_* from latched values; oMEM_CE=1; oMEM_RD=~wr; oMEM_WR=wr; oMEM_WSTRB=wr?wstrb:0. Decrement cnt. At cnt==0, capture iMEM_RDATA into the owner's read register (loads and fetches only) and go to RESP.
  - RESP: oMEM_* deasserted; pulse the owner's DONE for exactly one cycle; go to IDLE.
- All memory outputs are registered and 0 outside ACCESS. Address and data are stable for the whole of ACCESS, even if requester inputs change.
- Latency: request seen in IDLE at cycle n -> ACCESS in cycles n+1..n+MEM_LAT -> DONE at cycle n+MEM_LAT+1. The minimum per-access period is MEM_LAT+2 cycles.
- Requester rule: deassert REQ on the edge that samples DONE high. If REQ is still high in the following IDLE, it is treated as a new request.
- Arbitration in IDLE:
  - Only one REQ high -> grant it.
  - Both high -> grant LS unless ls_streak==MAX_LS_STREAK, in which case grant IF.
- ls_streak:
  - Increments (saturating) on an LS grant while iIF_REQ=1.
  - Clears on any IF grant, or on an LS grant while iIF_REQ=0.
- Stores: iMEM_RDATA ignored; oLS_RDATA keeps its previous value.
- oIF_DATA and oLS_RDATA hold their values until their next completed read.
- Requests arriving during ACCESS/RESP wait; no queueing beyond the level REQ.
- oIF_DONE and oLS_DONE are never high in the same cycle.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE/ACCESS/RESP, 2 bits) and owner IDs (OWN_IF=0, OWN_LS=1).
- Optional sub-module mem_arb_prio: combinational grant decision from (if_req, ls_req, ls_streak, MAX_LS_STREAK).
- Counter and datapath latches stay in the top module.

Test Plan:
- IF only, MEM_LAT=1, iIF_ADDR=0x10, iMEM_RDATA=0x00500093 -> oMEM_RD=1 and oMEM_ADDR=0x10 for 1 cycle; oIF_DONE pulses 2 cycles after the request; oIF_DATA=0x00500093.
- LS store, addr 0x80, wdata 0xDEADBEEF, wstrb 0x3, MEM_LAT=3 -> oMEM_WR=1 with stable addr/data/strobe for 3 cycles; oLS_DONE at cycle 4; oLS_RDATA unchanged.
- IF and LS both requesting continuously, LS re-requesting after each DONE, MAX_LS_STREAK=4 -> grant order LS,LS,LS,LS,IF,LS…; IF wait bounded to 4 accesses.
- Simultaneous single requests in IDLE -> LS granted first; IF completes one access later with the correct data.
- iRST asserted in the 2nd ACCESS cycle (MEM_LAT=3) -> all outputs 0 immediately; no DONE; after release, a held IF_REQ restarts a full access.
- REQ held high after DONE -> a second identical access is issued, starting in the following IDLE.
